commit_buf: RTL and testbench
=============================

# commit_buf

Retirement-record buffer between the writeback stage and the `Dbg` DPI bridge. It captures one commit record per accepted handshake: PC, instruction, GPR write, CSR write, ebreak flag and invalid-instruction flag. Records are held in a small FIFO and replayed to `Dbg` one per cycle as a single-cycle `done` pulse. After replaying an ebreak or invalid-instruction record, the block freezes so the simulator sees a clean final state.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h8000_0000: reset value of `dbg_pc`.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset.
- `in_valid`  in  1  writeback presents a retired instruction.
- `in_ready`  out  1  buffer can accept the record.
- `in_pc`, `in_inst`  in  32 each  retired PC and instruction word.
- `in_gpr_wen`  in  1  GPR write enable.
- `in_gpr_waddr`  in  5  GPR write address.
- `in_gpr_wdata`  in  32  GPR write data.
- `in_csr_wen`  in  1  CSR write enable.
- `in_csr_waddr`  in  12  CSR write address.
- `in_csr_wdata`  in  32  CSR write data.
- `in_brk`, `in_ivd`  in  1 each  ebreak retired; illegal instruction retired.
- `drain_en`  in  1  replay permitted this cycle; held 1 in normal runs.
- `dbg_pc`, `dbg_inst`  out  32 each  PC and instruction of the last replayed record.
- `dbg_done`  out  1  one-cycle pulse per replayed record.
- `dbg_gpr_wen`  out  1  replayed GPR write enable.
- `dbg_gpr_waddr`, `dbg_gpr_wdata`  out  32 each  replayed GPR address (zero-extended) and data.
- `dbg_csr_wen`  out  1  replayed CSR write enable.
- `dbg_csr_waddr`, `dbg_csr_wdata`  out  32 each  replayed CSR address (zero-extended) and data.
- `dbg_brk`, `dbg_ivd`  out  1 each  replayed ebreak and illegal-instruction flags.
- `halted`  out  1  high after an ebreak or illegal-instruction record has been replayed.

## Operation
- **States:** RUN and HALT. Reset enters RUN.
- **Push:** occurs when `in_valid && in_ready`. `in_ready = (state==RUN) && (count<DEPTH)`.
- **No pass-through:** a full FIFO does not accept a push, even when a pop happens in the same cycle.
- **Pop:** occurs when `state==RUN && count>0 && drain_en`. The head record loads into the `dbg_*` registers and `dbg_done` is 1 for that cycle.
- **Simultaneous push and pop:** `count` is unchanged; pointers wrap modulo DEPTH.
- **Enable qualification:** `dbg_gpr_wen`, `dbg_csr_wen`, `dbg_brk` and `dbg_ivd` are 0 in every cycle where `dbg_done` is 0.
- **Held outputs:** `dbg_pc`, `dbg_inst` and the address/data outputs hold their last values between pops, so `Dbg` change-triggered updates never fire spuriously.
- **x0 filtering:** a GPR write to x0 is stored with `wen` forced to 0.
- **Halt:** popping a record with `brk` or `ivd` moves the state to HALT at the same edge. In HALT:
  - no further pops occur;
  - `in_ready` is 0;
  - remaining entries are retained;
  - `halted` is 1.
  - HALT is left only by reset.
- **Flag priority:** if both `brk` and `ivd` are set in one record, both are replayed in the same pulse.
- **Reset values:**
  - `dbg_pc` = RESET_PC;
  - every other output = 0, except `in_ready`, which is 1 once reset is released;
  - FIFO is empty, pointers are 0, state is RUN.
- **Reset mid-operation:** all buffered records are discarded with no `dbg_done` pulse.

## Timing
- **Push latency:** a record pushed at edge k into an empty FIFO (with `drain_en=1`) appears on `dbg_*` with `dbg_done=1` after edge k+1.
- **Throughput:** one record per cycle sustained when `drain_en=1`.
- **`drain_en` low:** holds the FIFO. `in_ready` drops only when the FIFO becomes full.
- **Registered outputs:** all outputs are registered except `in_ready`, which is combinational from the state and count registers only; there is no input-to-output combinational path.

## Configuration
- `COMMIT_BUF_INSTRET_EN` defined: adds a 64-bit output `instret`, reset to 0. It increments by 1 on every pop, wraps at 2^64, and is frozen in HALT.
- `COMMIT_BUF_INSTRET_EN` undefined: the port and the counter are absent.

## Structure
- **Package `commit_pkg`:**
  - `commit_rec_t`, a packed struct with pc, inst, gpr_wen, gpr_waddr[4:0], gpr_wdata, csr_wen, csr_waddr[11:0], csr_wdata, brk, ivd;
  - state enum `cb_state_e` {CB_RUN, CB_HALT};
  - constant `COMMIT_RESET_PC`.
- **Sub-module `commit_fifo`:** parameterized on DEPTH. It holds storage, pointers and count, with push/pop/full/empty signals. It is reused by other trace consumers.

## Test plan
- **Single record:** push pc=0x80000000, inst=0x00500093, gpr x1=5 → one cycle later `dbg_done=1`, `dbg_gpr_wen=1`, `dbg_gpr_waddr=1`, `dbg_gpr_wdata=5`. Next cycle `dbg_done=0`, `dbg_gpr_wen=0`, `dbg_pc` held at 0x80000000.
- **x0 write:** push waddr=0, wen=1, wdata=0x1234 → replayed with `dbg_gpr_wen=0`.
- **Backpressure:** with `drain_en=0`, push 4 records → `in_ready=0` after the 4th. Raise `drain_en` → 4 consecutive `dbg_done` pulses in push order, and `in_ready` returns to 1 after the first pop.
- **Halt:** push pc 0x100 (normal), pc 0x104 (brk), pc 0x108 (normal) → two pulses; `dbg_brk=1` with `dbg_pc=0x104`; `halted=1`; 0x108 never replayed; `in_ready=0`.
- **Async reset:** assert `reset=0` mid-drain between clock edges with 3 records queued → outputs go to reset values immediately and no pulses follow after release.
- **Instret (with `COMMIT_BUF_INSTRET_EN`):** 10 pops → `instret=10`; the count stays at 10 after the halt.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared types for the commit-record path: record layout, buffer state and reset PC.
package commit_pkg;

  localparam logic [31:0] COMMIT_RESET_PC = 32'h8000_0000;

  typedef enum logic {
    CB_RUN  = 1'b0,
    CB_HALT = 1'b1
  } cb_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        brk;
    logic        ivd;
  } commit_rec_t;

endpackage

// File: rtl/commit_buf_if.sv
// Writeback-to-Dbg handshake bundle for commit_buf; instret exists only with COMMIT_BUF_INSTRET_EN.
interface commit_buf_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_gpr_wen;
  logic [4:0]  in_gpr_waddr;
  logic [31:0] in_gpr_wdata;
  logic        in_csr_wen;
  logic [11:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_brk;
  logic        in_ivd;
  logic        drain_en;

  logic [31:0] dbg_pc;
  logic [31:0] dbg_inst;
  logic        dbg_done;
  logic        dbg_gpr_wen;
  logic [31:0] dbg_gpr_waddr;
  logic [31:0] dbg_gpr_wdata;
  logic        dbg_csr_wen;
  logic [31:0] dbg_csr_waddr;
  logic [31:0] dbg_csr_wdata;
  logic        dbg_brk;
  logic        dbg_ivd;
  logic        halted;
`ifdef COMMIT_BUF_INSTRET_EN
  logic [63:0] instret;
`endif

  modport master (
    output in_valid, in_pc, in_inst, in_gpr_wen, in_gpr_waddr, in_gpr_wdata,
           in_csr_wen, in_csr_waddr, in_csr_wdata, in_brk, in_ivd, drain_en,
    input  in_ready, dbg_pc, dbg_inst, dbg_done, dbg_gpr_wen, dbg_gpr_waddr,
           dbg_gpr_wdata, dbg_csr_wen, dbg_csr_waddr, dbg_csr_wdata, dbg_brk,
           dbg_ivd, halted
`ifdef COMMIT_BUF_INSTRET_EN
         , instret
`endif
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_gpr_wen, in_gpr_waddr, in_gpr_wdata,
           in_csr_wen, in_csr_waddr, in_csr_wdata, in_brk, in_ivd, drain_en,
    output in_ready, dbg_pc, dbg_inst, dbg_done, dbg_gpr_wen, dbg_gpr_waddr,
           dbg_gpr_wdata, dbg_csr_wen, dbg_csr_waddr, dbg_csr_wdata, dbg_brk,
           dbg_ivd, halted
`ifdef COMMIT_BUF_INSTRET_EN
         , instret
`endif
  );
endinterface

// File: rtl/commit_fifo.sv
// Power-of-two FIFO of commit records; shared by the trace consumers.
module commit_fifo
  import commit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  commit_rec_t wdata_i,
  output commit_rec_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  commit_rec_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/commit_buf.sv
// Commit-record buffer replaying retired instructions to Dbg; freezes after ebreak/illegal.
// Optional COMMIT_BUF_INSTRET_EN adds a 64-bit retired-instruction counter.
module commit_buf
  import commit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = COMMIT_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  commit_buf_if.slave  bus
);

  cb_state_e   state_q, state_d;
  commit_rec_t in_rec, head;
  logic        full, empty, push, pop;

  logic [31:0] pc_q, inst_q, gpr_wdata_q, csr_wdata_q;
  logic [4:0]  gpr_waddr_q;
  logic [11:0] csr_waddr_q;
  logic        done_q, gpr_wen_q, csr_wen_q, brk_q, ivd_q;

  assign bus.in_ready = (state_q == CB_RUN) && !full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == CB_RUN) && !empty && bus.drain_en;

  // x0 is hard-wired zero, so a write to it is stored as no write at all.
  always_comb begin
    in_rec           = '0;
    in_rec.pc        = bus.in_pc;
    in_rec.inst      = bus.in_inst;
    in_rec.gpr_wen   = bus.in_gpr_wen && (bus.in_gpr_waddr != 5'd0);
    in_rec.gpr_waddr = bus.in_gpr_waddr;
    in_rec.gpr_wdata = bus.in_gpr_wdata;
    in_rec.csr_wen   = bus.in_csr_wen;
    in_rec.csr_waddr = bus.in_csr_waddr;
    in_rec.csr_wdata = bus.in_csr_wdata;
    in_rec.brk       = bus.in_brk;
    in_rec.ivd       = bus.in_ivd;
  end

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_rec),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // NOTE: default first so every path assigns state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (pop && (head.brk || head.ivd)) state_d = CB_HALT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CB_RUN;
    else        state_q <= state_d;
  end

  // Address/data hold between pops; enables and flags are qualified by the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      done_q      <= 1'b0;
      gpr_wen_q   <= 1'b0;
      csr_wen_q   <= 1'b0;
      brk_q       <= 1'b0;
      ivd_q       <= 1'b0;
    end else begin
      done_q    <= pop;
      gpr_wen_q <= pop && head.gpr_wen;
      csr_wen_q <= pop && head.csr_wen;
      brk_q     <= pop && head.brk;
      ivd_q     <= pop && head.ivd;
      if (pop) begin
        pc_q        <= head.pc;
        inst_q      <= head.inst;
        gpr_waddr_q <= head.gpr_waddr;
        gpr_wdata_q <= head.gpr_wdata;
        csr_waddr_q <= head.csr_waddr;
        csr_wdata_q <= head.csr_wdata;
      end
    end
  end

  assign bus.dbg_pc        = pc_q;
  assign bus.dbg_inst      = inst_q;
  assign bus.dbg_done      = done_q;
  assign bus.dbg_gpr_wen   = gpr_wen_q;
  assign bus.dbg_gpr_waddr = {27'd0, gpr_waddr_q};
  assign bus.dbg_gpr_wdata = gpr_wdata_q;
  assign bus.dbg_csr_wen   = csr_wen_q;
  assign bus.dbg_csr_waddr = {20'd0, csr_waddr_q};
  assign bus.dbg_csr_wdata = csr_wdata_q;
  assign bus.dbg_brk       = brk_q;
  assign bus.dbg_ivd       = ivd_q;
  assign bus.halted        = (state_q == CB_HALT);

`ifdef COMMIT_BUF_INSTRET_EN
  logic [63:0] instret_q;

  // Pops only happen in RUN, so the counter freezes on its own once halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   instret_q <= '0;
    else if (pop) instret_q <= instret_q + 64'd1;
  end

  assign bus.instret = instret_q;
`endif

endmodule

// File: tb/tb_commit_buf.sv
// Self-checking bench for commit_buf: queue-based reference model plus directed scenarios.
module tb_commit_buf;
  import commit_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  commit_buf_if bus ();

  commit_buf #(.DEPTH(DEPTH), .RESET_PC(COMMIT_RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of records plus the expected Dbg-side view.
  commit_rec_t q[$];
  bit          m_halt, m_done, m_gwen, m_cwen, m_brk, m_ivd;
  logic [31:0] m_pc, m_inst, m_gwa, m_gwd, m_cwa, m_cwd;
  logic [63:0] m_instret;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_halt && (q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete();
    m_halt = 0; m_done = 0; m_gwen = 0; m_cwen = 0; m_brk = 0; m_ivd = 0;
    m_pc = COMMIT_RESET_PC; m_inst = 0; m_gwa = 0; m_gwd = 0; m_cwa = 0; m_cwd = 0;
    m_instret = 0;
  endtask

  task automatic check_outputs();
    check("dbg_done",      bus.dbg_done,      m_done);
    check("dbg_pc",        bus.dbg_pc,        m_pc);
    check("dbg_inst",      bus.dbg_inst,      m_inst);
    check("dbg_gpr_wen",   bus.dbg_gpr_wen,   m_gwen);
    check("dbg_gpr_waddr", bus.dbg_gpr_waddr, m_gwa);
    check("dbg_gpr_wdata", bus.dbg_gpr_wdata, m_gwd);
    check("dbg_csr_wen",   bus.dbg_csr_wen,   m_cwen);
    check("dbg_csr_waddr", bus.dbg_csr_waddr, m_cwa);
    check("dbg_csr_wdata", bus.dbg_csr_wdata, m_cwd);
    check("dbg_brk",       bus.dbg_brk,       m_brk);
    check("dbg_ivd",       bus.dbg_ivd,       m_ivd);
    check("halted",        bus.halted,        m_halt);
`ifdef COMMIT_BUF_INSTRET_EN
    check("instret",       bus.instret,       m_instret);
`endif
  endtask

  task automatic drive(bit v, commit_rec_t r, bit drain);
    bus.in_valid     = v;
    bus.in_pc        = r.pc;
    bus.in_inst      = r.inst;
    bus.in_gpr_wen   = r.gpr_wen;
    bus.in_gpr_waddr = r.gpr_waddr;
    bus.in_gpr_wdata = r.gpr_wdata;
    bus.in_csr_wen   = r.csr_wen;
    bus.in_csr_waddr = r.csr_waddr;
    bus.in_csr_wdata = r.csr_wdata;
    bus.in_brk       = r.brk;
    bus.in_ivd       = r.ivd;
    bus.drain_en     = drain;
  endtask

  function automatic commit_rec_t mk(logic [31:0] pc, logic [31:0] inst, bit gwen,
                                     logic [4:0] gwa, logic [31:0] gwd, bit brk, bit ivd);
    commit_rec_t r;
    r = '0;
    r.pc = pc; r.inst = inst; r.gpr_wen = gwen; r.gpr_waddr = gwa; r.gpr_wdata = gwd;
    r.brk = brk; r.ivd = ivd;
    return r;
  endfunction

  function automatic commit_rec_t rand_rec();
    commit_rec_t r;
    r.pc        = $urandom;
    r.inst      = $urandom;
    r.gpr_wen   = $urandom_range(0, 1) == 1;
    r.gpr_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    r.gpr_wdata = $urandom;
    r.csr_wen   = $urandom_range(0, 1) == 1;
    r.csr_waddr = 12'($urandom);
    r.csr_wdata = $urandom;
    r.brk       = $urandom_range(0, 39) == 0;
    r.ivd       = $urandom_range(0, 39) == 0;
    return r;
  endfunction

  // One clock: drive at negedge, check in_ready, advance model, check registered outputs.
  task automatic step(bit v, commit_rec_t r, bit drain);
    bit          do_push, do_pop;
    commit_rec_t h, s;
    @(negedge clk);
    drive(v, r, drain);
    #1;
    check("in_ready", bus.in_ready, m_ready());
    do_push = v && m_ready();
    do_pop  = !m_halt && (q.size() > 0) && drain;
    if (do_pop) begin
      h = q.pop_front();
      m_done = 1; m_gwen = h.gpr_wen; m_cwen = h.csr_wen; m_brk = h.brk; m_ivd = h.ivd;
      m_pc = h.pc; m_inst = h.inst;
      m_gwa = 32'(h.gpr_waddr); m_gwd = h.gpr_wdata;
      m_cwa = 32'(h.csr_waddr); m_cwd = h.csr_wdata;
      m_instret = m_instret + 64'd1;
      if (h.brk || h.ivd) m_halt = 1;
    end else begin
      m_done = 0; m_gwen = 0; m_cwen = 0; m_brk = 0; m_ivd = 0;
    end
    if (do_push) begin
      s = r;
      if (s.gpr_waddr == 5'd0) s.gpr_wen = 1'b0;
      q.push_back(s);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(bit drain);
    step(1'b0, '0, drain);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_after_reset", bus.in_ready, 1'b1);
  endtask

  initial begin
    int halt_cycles;
    drive(1'b0, '0, 1'b1);
    model_reset();
    do_reset();

    // Single record with GPR write x1=5.
    step(1'b1, mk(32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0), 1'b1);
    check("single_no_done_yet", bus.dbg_done, 1'b0);
    idle(1'b1);
    check("single_done",  bus.dbg_done,      1'b1);
    check("single_wen",   bus.dbg_gpr_wen,   1'b1);
    check("single_waddr", bus.dbg_gpr_waddr, 32'd1);
    check("single_wdata", bus.dbg_gpr_wdata, 32'd5);
    idle(1'b1);
    check("single_done_low", bus.dbg_done,    1'b0);
    check("single_wen_low",  bus.dbg_gpr_wen, 1'b0);
    check("single_pc_held",  bus.dbg_pc,      32'h8000_0000);

    // x0 write is replayed without its enable.
    step(1'b1, mk(32'h8000_0004, 32'h0000_0013, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0), 1'b1);
    idle(1'b1);
    check("x0_done",  bus.dbg_done,      1'b1);
    check("x0_wen",   bus.dbg_gpr_wen,   1'b0);
    check("x0_wdata", bus.dbg_gpr_wdata, 32'h1234);

    // Backpressure: fill with drain off, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(32'h200 + 32'(4 * i), 32'h13, 1'b1, 5'(i + 2), 32'(i), 1'b0, 1'b0), 1'b0);
    check("bp_full_not_ready", bus.in_ready, 1'b0);
    idle(1'b1);
    check("bp_first_pc",        bus.dbg_pc,   32'h200);
    check("bp_ready_after_pop", bus.in_ready, 1'b1);
    for (int i = 1; i < DEPTH; i++) idle(1'b1);
    check("bp_last_pc", bus.dbg_pc, 32'h20c);
    idle(1'b1);

    // Halt on ebreak; the record behind it stays buffered and never replays.
    do_reset();
    step(1'b1, mk(32'h100, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b1);
    step(1'b1, mk(32'h104, 32'h0010_0073, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0), 1'b1);
    check("halt_first_pc", bus.dbg_pc, 32'h100);
    step(1'b1, mk(32'h108, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b1);
    check("halt_brk",    bus.dbg_brk, 1'b1);
    check("halt_brk_pc", bus.dbg_pc,  32'h104);
    check("halt_flag",   bus.halted,  1'b1);
    check("halt_ready",  bus.in_ready, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(32'h10c, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b1);
    check("halt_pc_frozen", bus.dbg_pc, 32'h104);

    // Both flags in one record replay together.
    do_reset();
    step(1'b1, mk(32'h300, 32'h0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1), 1'b1);
    idle(1'b1);
    check("both_brk", bus.dbg_brk, 1'b1);
    check("both_ivd", bus.dbg_ivd, 1'b1);

    // Asynchronous reset between edges with three records still queued.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(32'h400 + 32'(4 * i), 32'h13, 1'b1, 5'd3, 32'(i), 1'b0, 1'b0), 1'b0);
    idle(1'b1);
    check("ar_pulse_before", bus.dbg_done, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("ar_done_cleared", bus.dbg_done, 1'b0);
    check("ar_pc_reset",     bus.dbg_pc,   COMMIT_RESET_PC);
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("ar_no_pulse", bus.dbg_done, 1'b0);
    end

`ifdef COMMIT_BUF_INSTRET_EN
    // Ten retirements, the last one an ebreak; counter freezes after the halt.
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, mk(32'h500 + 32'(4 * i), 32'h13, 1'b0, 5'd0, 32'd0, i == 9, 1'b0), 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("instret_10", bus.instret, 64'd10);
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(32'h600, 32'h13, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0), 1'b1);
    check("instret_frozen", bus.instret, 64'd10);
`endif

    // Randomized traffic against the model, resetting a few cycles after each halt.
    do_reset();
    halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, rand_rec(), $urandom_range(0, 3) != 0);
      if (m_halt) halt_cycles++;
      if (halt_cycles > 3) begin
        do_reset();
        halt_cycles = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
